// File: rtl/rr_sel_pkg.sv
// Shared types and select-code constants for the round-robin select arbiter
// and the downstream case-decoded output mux.
package rr_sel_pkg;

   localparam int NREQ = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      GAP  = 2'b10
   } state_e;

   localparam logic [1:0] SEL_ZERO  = 2'd0;
   localparam logic [1:0] SEL_ONE   = 2'd1;
   localparam logic [1:0] SEL_TWO   = 2'd2;
   localparam logic [1:0] SEL_THREE = 2'd3;

   function automatic logic [NREQ-1:0] sel2gnt(input logic [1:0] code);
      sel2gnt = '0;
      sel2gnt[code] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority picker: first set request bit searching
// from ptr upwards, modulo 4.
module rr_pick4
   import rr_sel_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic            any,
   output logic [1:0]      idx
);

   logic [NREQ-1:0] rot;
   logic [1:0]      off;

   always_comb begin
      rot = req;
      // Rotate so that requester ptr lands on bit 0, then pick the lowest set bit.
      case (ptr)
         SEL_ZERO:  rot = req;
         SEL_ONE:   rot = {req[0],   req[3:1]};
         SEL_TWO:   rot = {req[1:0], req[3:2]};
         SEL_THREE: rot = {req[2:0], req[3]};
         default:   rot = req;
      endcase

      off = 2'd0;
      casez (rot)
         4'b???1: off = 2'd0;
         4'b??10: off = 2'd1;
         4'b?100: off = 2'd2;
         4'b1000: off = 2'd3;
         default: off = 2'd0;
      endcase

      any = |req;
      idx = ptr + off;
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Four-way round-robin arbiter driving the registered 2-bit select code of the
// downstream output mux, with done/withdraw release and a hold-limit timeout.
module rr_sel_arbiter
   import rr_sel_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [1:0]      sel,
   output logic            sel_vld,
   output logic [NREQ-1:0] gnt,
   output logic            timeout
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic              sel_vld_q, sel_vld_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              pick_any;
   logic [1:0]        pick_idx;
   logic              rel;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      sel_vld_d  = sel_vld_q;
      gnt_d      = gnt_q;
      hold_cnt_d = hold_cnt_q;
      timeout    = 1'b0;
      rel        = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d      = pick_idx;
               sel_vld_d  = 1'b1;
               gnt_d      = sel2gnt(pick_idx);
               hold_cnt_d = HOLD_W'(1);
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // timeout is decided in the same cycle as the limit is reached, so
            // it coincides with the last granted cycle; done/withdraw mask it.
            if (done || !req[sel_q]) begin
               rel = 1'b1;
            end else if (hold_cnt_q == HOLD_MAX) begin
               rel     = 1'b1;
               timeout = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            sel_d      = SEL_ZERO;
            ptr_d      = SEL_ZERO;
            sel_vld_d  = 1'b0;
            gnt_d      = '0;
            hold_cnt_d = '0;
         end
      endcase

      if (rel) begin
         sel_vld_d  = 1'b0;
         gnt_d      = '0;
         hold_cnt_d = '0;
         ptr_d      = sel_q + 2'd1;
         state_d    = GAP;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= SEL_ZERO;
         ptr_q      <= SEL_ZERO;
         sel_vld_q  <= 1'b0;
         gnt_q      <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         sel_vld_q  <= sel_vld_d;
         gnt_q      <= gnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign sel     = sel_q;
   assign sel_vld = sel_vld_q;
   assign gnt     = gnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter: the driver queues expected grants, a
// negedge monitor checks each grant's code, length, timeout position and gap.
module tb_rr_sel_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [1:0] sel;
   logic       sel_vld;
   logic [3:0] gnt;
   logic       timeout;

   logic [3:0] req1 = 4'b0000;
   logic       done1 = 1'b0;
   logic [1:0] sel1;
   logic       sel_vld1;
   logic [3:0] gnt1;
   logic       timeout1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0] sel;
      int         len;    // -1: not checked
      int         to_at;  // 1-based granted cycle carrying timeout, 0: none
      int         gap;    // low cycles before this grant, -1: not checked
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   rr_sel_arbiter #(.MAX_HOLD(8)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .sel_vld (sel_vld),
      .gnt     (gnt),
      .timeout (timeout)
   );

   rr_sel_arbiter #(.MAX_HOLD(1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req1),
      .done    (done1),
      .sel     (sel1),
      .sel_vld (sel_vld1),
      .gnt     (gnt1),
      .timeout (timeout1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_grant(input logic [1:0] s, input int l, input int t, input int g);
      exp_t e;
      e.sel = s; e.len = l; e.to_at = t; e.gap = g;
      q.push_back(e);
   endtask

   // Polls sel_vld 1 time unit after each rising edge; bounded.
   task automatic wait_vld(input logic lvl, input string what);
      int n = 0;
      while (sel_vld !== lvl && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (sel_vld !== lvl) check(what, 32'(sel_vld), 32'(lvl));
   endtask

   // Monitor
   exp_t cur;
   bit   inflight = 0;
   bit   seen_fall = 0;
   logic prev_vld = 1'b0;
   int   len_cnt = 0, to_cnt = 0, to_at_seen = 0, low_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         inflight  = 0;
         seen_fall = 0;
         low_cnt   = 0;
         prev_vld  = 1'b0;
      end else begin
         if (sel_vld && !prev_vld) begin
            if (q.size() == 0) begin
               check("unexpected_grant", 32'(sel_vld), 32'd0);
            end else begin
               cur = q.pop_front();
               check("grant_sel", 32'(sel), 32'(cur.sel));
               check("grant_gnt", 32'(gnt), 32'(1) << cur.sel);
               if (cur.gap >= 0 && seen_fall) check("grant_gap", 32'(low_cnt), 32'(cur.gap));
               inflight = 1; len_cnt = 0; to_cnt = 0; to_at_seen = 0;
            end
         end
         if (sel_vld) begin
            len_cnt++;
            if (timeout) begin
               to_cnt++;
               to_at_seen = len_cnt;
            end
         end else begin
            check("idle_gnt", 32'(gnt), 32'd0);
            check("idle_timeout", 32'(timeout), 32'd0);
         end
         if (!sel_vld && prev_vld && inflight) begin
            if (cur.len >= 0) check("grant_len", 32'(len_cnt), 32'(cur.len));
            check("timeout_at", 32'(to_at_seen), 32'(cur.to_at));
            check("timeout_cnt", 32'(to_cnt), (cur.to_at != 0) ? 32'd1 : 32'd0);
            inflight = 0; seen_fall = 1; low_cnt = 0;
         end
         if (!sel_vld) low_cnt++;
         prev_vld = sel_vld;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_vld", 32'(sel_vld), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;

      // MAX_HOLD=1 instance: one-cycle grants with timeout on the granted cycle
      req1 = 4'b0001;
      @(negedge clk);
      check("mh1_latency_vld", 32'(sel_vld1), 32'd0);
      @(negedge clk);
      check("mh1_vld_a", 32'(sel_vld1), 32'd1);
      check("mh1_sel_a", 32'(sel1), 32'd0);
      check("mh1_gnt_a", 32'(gnt1), 32'h1);
      check("mh1_to_a", 32'(timeout1), 32'd1);
      @(negedge clk);
      check("mh1_gap_vld", 32'(sel_vld1), 32'd0);
      check("mh1_gap_to", 32'(timeout1), 32'd0);
      @(negedge clk);
      check("mh1_idle_vld", 32'(sel_vld1), 32'd0);
      @(negedge clk);
      check("mh1_vld_b", 32'(sel_vld1), 32'd1);
      check("mh1_to_b", 32'(timeout1), 32'd1);
      req1 = 4'b0000;
      @(posedge clk); #1;

      // Rotation with done one cycle after each grant
      expect_grant(2'd0, 1, 0, -1);
      expect_grant(2'd1, 1, 0, 2);
      expect_grant(2'd2, 1, 0, 2);
      expect_grant(2'd3, 1, 0, 2);
      expect_grant(2'd0, 1, 0, 2);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_vld(1'b1, "rot_grant_wait");
         done = 1'b1;
         wait_vld(1'b0, "rot_release_wait");
         done = 1'b0;
      end

      // Timeout on a held request, then the same requester again with done on the limit cycle
      expect_grant(2'd2, 8, 8, 2);
      expect_grant(2'd2, 8, 0, 2);
      req = 4'b0100;
      wait_vld(1'b1, "to_grant_wait");
      wait_vld(1'b0, "to_release_wait");
      wait_vld(1'b1, "sim_grant_wait");
      repeat (7) @(posedge clk);
      #1;
      done = 1'b1;
      wait_vld(1'b0, "sim_release_wait");
      done = 1'b0;

      // Withdrawal from ptr=3 and wrap to 0, then withdrawal hands over to 1
      expect_grant(2'd3, 1, 0, 2);
      expect_grant(2'd0, 1, 0, 2);
      expect_grant(2'd1, 1, 0, 2);
      req = 4'b1001;
      wait_vld(1'b1, "wd_grant_wait");
      req = 4'b0001;
      wait_vld(1'b0, "wd_release_wait");
      wait_vld(1'b1, "wrap_grant_wait");
      req = 4'b0010;
      wait_vld(1'b0, "wrap_release_wait");
      wait_vld(1'b1, "one_grant_wait");
      req = 4'b0000;
      done = 1'b1;
      wait_vld(1'b0, "one_release_wait");
      done = 1'b0;

      // Idle stability with stray done pulses
      for (int i = 0; i < 20; i++) begin
         done = (i % 3 == 0);
         @(negedge clk);
         check("idle_sel", 32'(sel), 32'd1);
         check("idle_vld", 32'(sel_vld), 32'd0);
         @(posedge clk); #1;
      end
      done = 1'b0;

      // Asynchronous reset mid-grant, then restart from ptr=0
      expect_grant(2'd2, -1, 0, -1);
      req = 4'b0100;
      wait_vld(1'b1, "rst_grant_wait");
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_sel", 32'(sel), 32'd0);
      check("arst_vld", 32'(sel_vld), 32'd0);
      check("arst_gnt", 32'(gnt), 32'd0);
      check("arst_timeout", 32'(timeout), 32'd0);
      @(posedge clk); #1;
      req = 4'b1111;
      expect_grant(2'd0, 1, 0, -1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_vld(1'b1, "post_rst_grant_wait");
      done = 1'b1;
      wait_vld(1'b0, "post_rst_release_wait");
      done = 1'b0;
      req = 4'b0000;

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that produces the registered 2-bit select code for the downstream case-decoded output mux (codes 0..3).
- Among four requesters it picks one, holds the grant until the requester is done or a hold limit expires, then rotates priority.
- The select output is always driven to a known code (never X/Z), so the downstream decoder never sees an uncovered value.

Parameters:
- MAX_HOLD, 8: maximum number of cycles one grant may last before forced release. Legal range is 1..255.
- HOLD_W, $clog2(MAX_HOLD+1): width of the hold counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i is requester i. Level-sensitive.
- done  input  1  current owner finished; sampled only while busy.
- sel  output  2  registered select code to the downstream mux; equals the index of the granted requester.
- sel_vld  output  1  high while a grant is active.
- gnt  output  4  one-hot grant; equals 1<<sel when sel_vld is high, otherwise 0.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset (async assert, sync-safe deassert not required here) forces:
  - sel=2'b00, sel_vld=0, gnt=4'b0000, timeout=0
  - internal ptr=2'b00, hold_cnt=0, state=IDLE
- States: IDLE, BUSY, GAP. State encoding is 2 bits. The unused encoding decodes through a default branch to IDLE with all outputs at reset values. Every case statement carries a default.
- IDLE:
  - If req==0, stay in IDLE; sel holds its last value.
  - Otherwise pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: sel=winner, sel_vld=1, gnt=one-hot(winner), hold_cnt=1, state=BUSY.
  - Latency is exactly one cycle from req seen to sel_vld.
- BUSY (evaluated each cycle), in priority order:
  1. done=1: release with no timeout.
  2. req[sel]=0: release with no timeout (requester withdrew).
  3. hold_cnt==MAX_HOLD: release and pulse timeout=1 for one cycle.
  4. Otherwise stay in BUSY and increment hold_cnt (saturating at MAX_HOLD).
- Release (any cause):
  - Next cycle: sel_vld=0, gnt=0, state=GAP.
  - ptr=sel+1 with 2-bit wrap (3 -> 0).
  - sel keeps the released code; it is not cleared.
- GAP: one mandatory idle cycle (sel_vld=0) so the downstream stage sees a clean boundary; then go to IDLE unconditionally.
- Back-to-back requests: minimum spacing from one sel_vld fall to the next sel_vld rise is 2 cycles (GAP, then IDLE arbitration).
- done asserted in IDLE or GAP is ignored.
- Simultaneous done and hold limit: done wins and timeout stays 0.
- MAX_HOLD=1: every grant lasts exactly one cycle unless done or withdrawal releases it; timeout pulses when neither does.
- Reset mid-grant: outputs clear immediately, asynchronously. After reset deassertion, arbitration restarts from ptr=0.
- Invariant, for checking: gnt is always 0 or one-hot, and gnt!=0 if and only if sel_vld=1.

Decomposition:
- Shared package rr_sel_pkg holds:
  - state typedef {IDLE, BUSY, GAP}
  - select code constants SEL_ZERO=0, SEL_ONE=1, SEL_TWO=2, SEL_THREE=3, also used by the downstream decoder
  - NREQ=4 constant
- One sub-module is natural: rr_pick4, a combinational priority rotator. Inputs are req[3:0] and ptr[1:0]; outputs are any and idx[1:0]. It has a default branch. Everything else stays in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY with sel=2 -> sel=0, sel_vld=0, gnt=0 in the same cycle without waiting for an edge; first grant after release with req=4'b1111 is sel=0.
- Rotation: hold req=4'b1111 and pulse done 1 cycle after each grant -> sel sequence 0,1,2,3,0 with a 2-cycle sel_vld gap between grants.
- Timeout: MAX_HOLD=8, req=4'b0100 held, done=0 -> sel=2 and sel_vld high for 8 cycles, timeout=1 for exactly one cycle on the 8th, next grant goes to 2 again after the GAP.
- Simultaneous: done=1 on the cycle hold_cnt==MAX_HOLD -> timeout stays 0, release is normal.
- Withdrawal and wrap: ptr=3, req=4'b1001 -> sel=3; drop req[3] -> release, ptr wraps to 0, next grant is sel=0.
- Idle stability: req=0 for 20 cycles after a grant to 1 -> sel stays 1, sel_vld=0, gnt=0, and done pulses are ignored.
